// File: rtl/router_dest_ctrl.sv
// router_dest_ctrl: latches the packet destination, steers FIFO writes,
// flags valid data and soft-resets a port after TIMEOUT stalled cycles.
//
// Ports:
//   clock, resetn                  clock, synchronous active-low reset
//   detect_add, data_in[1:0]       capture destination address
//   write_enb_reg                  FSM write request for current byte
//   empty_n, full_n                FIFO status flags (n = 0..2)
//   read_enb_n                     client read strobes
//   write_enb[2:0]                 one-hot FIFO write enable
//   fifo_full                      full flag of selected FIFO
//   vld_out_n                      data valid to client n
//   soft_reset_n                   registered timeout pulse for port n
module router_dest_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [1:0] addr;
  logic [2:0] empty_v;
  logic [2:0] rd_v;
  logic [2:0] stall;
  logic [2:0] sr;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr <= 2'b00;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  // Decode from the registered address so a same-cycle capture
  // only takes effect on the following byte.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    unique case (addr)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      2'b11: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  assign empty_v = {empty_2, empty_1, empty_0};
  assign rd_v    = {read_enb_2, read_enb_1, read_enb_0};
  assign stall   = ~empty_v & ~rd_v;

  for (genvar n = 0; n < 3; n++) begin : g_port
    logic [CW-1:0] cnt;
    logic          sr_q;

    // Count wraps to 0 on the pulse so a held stall re-fires
    // every TIMEOUT cycles.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        cnt  <= '0;
        sr_q <= 1'b0;
      end else if (stall[n]) begin
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          sr_q <= 1'b1;
        end else begin
          cnt  <= cnt + CW'(1);
          sr_q <= 1'b0;
        end
      end else begin
        cnt  <= '0;
        sr_q <= 1'b0;
      end
    end

    assign sr[n] = sr_q;
  end

  assign soft_reset_0 = sr[0];
  assign soft_reset_1 = sr[1];
  assign soft_reset_2 = sr[2];

endmodule

// File: tb/tb_router_dest_ctrl.sv
// Bench for router_dest_ctrl: vector table, corner sequences and
// random traffic against a stall-run-length reference model.
module tb_router_dest_ctrl;

  localparam int T = 30;

  logic       clock = 1'b0;
  logic       resetn, detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  router_dest_ctrl #(.TIMEOUT(T)) dut (
    .clock(clock), .resetn(resetn),
    .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1),
    .read_enb_2(read_enb_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1),
    .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rstn;
    logic       det;
    logic [1:0] din;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] rd;
    logic       chk;
    logic [2:0] we;
    logic       ff;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: destination and length of current stall run.
  logic [1:0] m_addr;
  int         m_run [3];
  logic [2:0] m_sr;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rstn, input logic [2:0] empty,
                              input logic [2:0] rd);
    vec_t v;
    v.rstn = rstn; v.det = 1'b0; v.din = 2'b00; v.wr = 1'b0;
    v.full = 3'b000; v.empty = empty; v.rd = rd;
    v.chk = 1'b0; v.we = 3'b000; v.ff = 1'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [2:0] e_we;
    logic       e_ff;
    resetn = v.rstn; detect_add = v.det; data_in = v.din;
    write_enb_reg = v.wr;
    {full_2, full_1, full_0} = v.full;
    {empty_2, empty_1, empty_0} = v.empty;
    {read_enb_2, read_enb_1, read_enb_0} = v.rd;
    #1;
    e_we = (v.wr && m_addr != 2'd3) ? 3'(1 << m_addr) : 3'b000;
    e_ff = (m_addr == 2'd3) ? 1'b0 : v.full[m_addr];
    chk("model_we", {5'b0, write_enb}, {5'b0, e_we});
    chk("model_ff", {7'b0, fifo_full}, {7'b0, e_ff});
    chk("vld", {5'b0, vld_out_2, vld_out_1, vld_out_0},
        {5'b0, ~v.empty});
    if (v.chk) begin
      chk("tbl_we", {5'b0, write_enb}, {5'b0, v.we});
      chk("tbl_ff", {7'b0, fifo_full}, {7'b0, v.ff});
    end
    @(posedge clock);
    if (!v.rstn) begin
      m_addr = 2'b00;
      for (int p = 0; p < 3; p++) m_run[p] = 0;
      m_sr = 3'b000;
    end else begin
      if (v.det) m_addr = v.din;
      for (int p = 0; p < 3; p++) begin
        if (!v.empty[p] && !v.rd[p]) m_run[p]++;
        else m_run[p] = 0;
        m_sr[p] = (m_run[p] > 0) && (m_run[p] % T == 0);
      end
    end
    #1;
    chk("model_sr", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0},
        {5'b0, m_sr});
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    // rstn det din wr full we ff
    tbl[0]  = '{0, 0, 2'b00, 1, 3'b001, 3'b111, 3'b000, 1, 3'b001, 1};
    tbl[1]  = '{1, 1, 2'b01, 0, 3'b010, 3'b111, 3'b000, 1, 3'b000, 0};
    tbl[2]  = '{1, 0, 2'b00, 1, 3'b010, 3'b111, 3'b000, 1, 3'b010, 1};
    tbl[3]  = '{1, 1, 2'b11, 1, 3'b010, 3'b111, 3'b000, 1, 3'b010, 1};
    tbl[4]  = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b000, 1, 3'b000, 0};
    tbl[5]  = '{1, 1, 2'b10, 1, 3'b100, 3'b111, 3'b000, 1, 3'b000, 0};
    tbl[6]  = '{1, 0, 2'b00, 1, 3'b100, 3'b111, 3'b000, 1, 3'b100, 1};
    tbl[7]  = '{1, 1, 2'b00, 1, 3'b100, 3'b111, 3'b000, 1, 3'b100, 1};
    tbl[8]  = '{1, 0, 2'b00, 1, 3'b001, 3'b111, 3'b000, 1, 3'b001, 1};
    tbl[9]  = '{1, 0, 2'b00, 0, 3'b001, 3'b111, 3'b000, 1, 3'b000, 1};
    tbl[10] = '{0, 1, 2'b10, 1, 3'b000, 3'b111, 3'b000, 1, 3'b001, 0};
    tbl[11] = '{1, 0, 2'b00, 1, 3'b001, 3'b111, 3'b000, 1, 3'b001, 1};

    m_addr = 2'b00;
    m_sr = 3'b000;
    for (int p = 0; p < 3; p++) m_run[p] = 0;

    // Unchecked first edge: addr is unknown until reset is sampled.
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00;
    write_enb_reg = 1'b0;
    {full_2, full_1, full_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    @(posedge clock);
    #1;
    chk("rst_sr", {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, 8'h0);

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Port 2 held stalled: pulse after 30th and 60th edge only.
    apply(mk(1, 3'b111, 3'b000));
    for (int i = 1; i <= 61; i++) begin
      apply(mk(1, 3'b011, 3'b000));
      chk("p2_timeout", {7'b0, soft_reset_2},
          {7'b0, (i == 30 || i == 60)});
    end

    // Port 0: one read after 29 stalls restarts the count.
    apply(mk(1, 3'b111, 3'b000));
    for (int i = 1; i <= 29; i++) begin
      apply(mk(1, 3'b110, 3'b000));
      chk("p0_pre", {7'b0, soft_reset_0}, 8'h0);
    end
    apply(mk(1, 3'b110, 3'b001));
    chk("p0_read", {7'b0, soft_reset_0}, 8'h0);
    for (int i = 1; i <= 30; i++) begin
      apply(mk(1, 3'b110, 3'b000));
      chk("p0_restart", {7'b0, soft_reset_0}, {7'b0, (i == 30)});
    end

    // Ports 0 and 1 together, port 2 empty.
    apply(mk(1, 3'b111, 3'b000));
    for (int i = 1; i <= 30; i++) begin
      apply(mk(1, 3'b100, 3'b000));
      chk("p01_sync",
          {5'b0, soft_reset_2, soft_reset_1, soft_reset_0},
          (i == 30) ? 8'h3 : 8'h0);
    end

    // Port 1: reset mid-count discards the partial count.
    apply(mk(1, 3'b111, 3'b000));
    for (int i = 1; i <= 20; i++) begin
      v = mk(1, 3'b101, 3'b000);
      if (i == 1) begin v.det = 1'b1; v.din = 2'b10; end
      apply(v);
    end
    apply(mk(0, 3'b101, 3'b000));
    chk("p1_rst", {7'b0, soft_reset_1}, 8'h0);
    for (int i = 1; i <= 30; i++) begin
      v = mk(1, 3'b101, 3'b000);
      if (i == 1) begin v.wr = 1'b1; v.chk = 1'b1; v.we = 3'b001; end
      apply(v);
      chk("p1_post_rst", {7'b0, soft_reset_1}, {7'b0, (i == 30)});
    end

    // Random traffic; sparse reads and empties give long stalls.
    for (int i = 0; i < 3000; i++) begin
      v = mk(($urandom_range(0, 299) != 0),
             {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0)},
             {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 39) == 0)});
      v.det  = ($urandom_range(0, 7) == 0);
      v.din  = 2'($urandom_range(0, 3));
      v.wr   = 1'($urandom_range(0, 1));
      v.full = 3'($urandom_range(0, 7));
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_dest_ctrl.md
ROUTER_DEST_CTRL -- requirements
Module: router_dest_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 30, meaning consecutive stalled cycles before a port soft reset; legal range 2..255.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 detect_add  input  1  FSM decode-address indication; capture destination this cycle.
REQ-005 data_in  input  2  destination address from header byte bits [1:0].
REQ-006 write_enb_reg  input  1  FSM request to write current byte into the selected FIFO.
REQ-007 empty_0, empty_1, empty_2  input  1 each  FIFO empty flags.
REQ-008 full_0, full_1, full_2  input  1 each  FIFO full flags.
REQ-009 read_enb_0, read_enb_1, read_enb_2  input  1 each  downstream client read strobes.
REQ-010 write_enb  output  3  one-hot FIFO write enable, bit n selects FIFO n.
REQ-011 fifo_full  output  1  full flag of the selected FIFO, returned to the FSM.
REQ-012 vld_out_0, vld_out_1, vld_out_2  output  1 each  data-valid to client n.
REQ-013 soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  registered timeout pulse to FIFO n and FSM.

Function
REQ-014 2-bit address register addr SHALL load data_in on any rising edge with resetn=1 and detect_add=1; otherwise hold.
REQ-015 write_enb SHALL be combinational: write_enb_reg=0 -> 3'b000; else addr 00 -> 3'b001, 01 -> 3'b010, 10 -> 3'b100, 11 -> 3'b000.
REQ-016 fifo_full SHALL be combinational: addr 00 -> full_0, 01 -> full_1, 10 -> full_2, 11 -> 0.
REQ-017 Decode in REQ-015/016 SHALL use the registered addr; detect_add and write_enb_reg asserted in the same cycle use the pre-capture addr.
REQ-018 vld_out_n SHALL equal ~empty_n combinationally, independent of addr.
REQ-019 Each port n SHALL own an independent counter cnt_n, width ceil(log2(TIMEOUT)), no wrap past TIMEOUT-1.
REQ-020 Port n is stalled in a cycle when vld_out_n=1 and read_enb_n=0.
REQ-021 Stalled and cnt_n < TIMEOUT-1: cnt_n increments, soft_reset_n <= 0.
REQ-022 Stalled and cnt_n = TIMEOUT-1: cnt_n <= 0, soft_reset_n <= 1 for exactly one cycle.
REQ-023 Not stalled: cnt_n <= 0, soft_reset_n <= 0; any single read or empty cycle restarts the count.
REQ-024 soft_reset_n first asserts in the cycle after the TIMEOUT-th consecutive stalled rising edge; under continued stall it repeats every TIMEOUT cycles.
REQ-025 Ports SHALL time out independently; simultaneous soft_reset on several ports is legal.
REQ-026 soft_reset_n SHALL NOT alter addr, write_enb or fifo_full.

Reset
REQ-027 On a rising edge with resetn=0: addr <= 2'b00, cnt_0..2 <= 0, soft_reset_0..2 <= 0; this overrides detect_add and stall.
REQ-028 During reset, write_enb and fifo_full still follow REQ-015/016 with addr=00; vld_out follows empty.
REQ-029 Reset asserted mid-count SHALL discard partial counts; counting restarts from 0 after release.

Verification
REQ-030 detect_add=1, data_in=01, next cycle write_enb_reg=1, full_1=1 -> write_enb=3'b010, fifo_full=1; data_in=11 captured -> write_enb=000, fifo_full=0.
REQ-031 empty_2=0, read_enb_2=0 held 30 edges (TIMEOUT=30) -> soft_reset_2=1 one cycle after 30th edge, low next cycle; re-pulses 30 cycles later if still stalled.
REQ-032 empty_0=0, stall 29 cycles, read_enb_0=1 one cycle, stall again -> no pulse until 30 further stalled edges.
REQ-033 Ports 0 and 1 stalled from same edge -> soft_reset_0 and soft_reset_1 pulse in the same cycle; port 2 (empty_2=1) stays 0.
REQ-034 Stall port 1 for 20 cycles, resetn=0 one edge, stall continues -> soft_reset_1 only after 30 stalled edges post-release; addr reads 00 after reset.
REQ-035 detect_add and write_enb_reg both 1 with addr=10, data_in=00 -> write_enb=3'b100 that cycle, 3'b001 next cycle.
